sa_array_os: RTL and testbench

Parametrised output-stationary systolic array core: `ROWS`×`COLS` processing elements accumulate `K_LEN`-deep signed dot products of streamed activation and weight vectors. It replaces the fixed 8-row core in the accelerator datapath. It adds:
- internal input skewing;
- tolerance of input bubbles;
- a tile FSM;
- a column-serial drain with back-pressure.

---
 rtl/sa_pkg.sv | 46 ++++
 rtl/sa_pe.sv | 79 +++++++
 rtl/sa_array_os.sv | 269 ++++++++++++++++++++++++++
 tb/tb_sa_array_os.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared definitions for the output-stationary systolic array core:
// tile FSM state encoding, counter-width helper and the clamping adder
// used by the accumulators when SA_SATURATE_EN is defined.
package sa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } sa_state_e;

  // Widest accumulator the clamping adder supports.
  localparam int SAT_MAX_W = 63;

  // Bits needed to hold any value in 0..max_val (at least one bit).
  function automatic int cnt_w(input int max_val);
    if (max_val < 2) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

  // Signed add of two sign-extended operands, clamped to the range of an
  // acc_w-bit two's complement value. Operands and result are carried in
  // 64 bits; the caller truncates to its accumulator width.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int          acc_w);
    logic signed [64:0] s;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    s  = $signed({a[63], a}) + $signed({b[63], b});
    hi = (65'sd1 <<< (acc_w - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (acc_w - 1));
    if (s > hi) begin
      return hi[63:0];
    end else if (s < lo) begin
      return lo[63:0];
    end else begin
      return s[63:0];
    end
  endfunction

endpackage

// File: rtl/sa_pe.sv
// Single processing element of the output-stationary array.
// Activations (with valid/first tags) move right, weights move down, each
// through one register. The local accumulator adds a*w on every beat where
// both operand streams are valid; the tile's first beat overwrites it.
// Optional feature macro: SA_SATURATE_EN (clamp instead of wrap).
module sa_pe
  import sa_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic                     i_a_v,
  input  logic                     i_a_f,
  input  logic signed [DATA_W-1:0] i_w,
  input  logic                     i_w_v,
  input  logic                     i_w_f,
  output logic signed [DATA_W-1:0] o_a,
  output logic                     o_a_v,
  output logic                     o_a_f,
  output logic signed [DATA_W-1:0] o_w,
  output logic                     o_w_v,
  output logic                     o_w_f,
  output logic signed [ACC_W-1:0]  o_acc
);

  logic signed [2*DATA_W-1:0] w_a_ext;
  logic signed [2*DATA_W-1:0] w_w_ext;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    w_sum;
  logic signed [ACC_W-1:0]    r_acc;
  logic                       w_fire;
  logic                       w_first;

  // Full-precision signed product, then sign-extended to the accumulator.
  assign w_a_ext    = (2*DATA_W)'(i_a);
  assign w_w_ext    = (2*DATA_W)'(i_w);
  assign w_prod     = w_a_ext * w_w_ext;
  assign w_prod_ext = ACC_W'(w_prod);

  // Both skewed streams carry the same valid/first tags when aligned.
  assign w_fire  = i_a_v & i_w_v;
  assign w_first = i_a_f & i_w_f;

`ifdef SA_SATURATE_EN
  assign w_sum = ACC_W'(sat_add(64'(r_acc), 64'(w_prod_ext), ACC_W));
`else
  assign w_sum = r_acc + w_prod_ext;
`endif

  assign o_acc = r_acc;

  // Operand forwarding registers and the accumulator.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_a   <= '0;
      o_a_v <= 1'b0;
      o_a_f <= 1'b0;
      o_w   <= '0;
      o_w_v <= 1'b0;
      o_w_f <= 1'b0;
      r_acc <= '0;
    end else begin
      o_a   <= i_a;
      o_a_v <= i_a_v;
      o_a_f <= i_a_f;
      o_w   <= i_w;
      o_w_v <= i_w_v;
      o_w_f <= i_w_f;
      if (w_fire) begin
        r_acc <= w_first ? w_prod_ext : w_sum;
      end
    end
  end

endmodule

// File: rtl/sa_array_os.sv
// Output-stationary systolic array core: ROWS x COLS grid of sa_pe fed
// through internal skew chains, a tile FSM (IDLE/LOAD/FLUSH/DRAIN) and a
// column-serial registered drain with back-pressure via out_read.
// Optional feature macro: SA_SATURATE_EN (accumulators clamp instead of wrap).
module sa_array_os
  import sa_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int K_LEN  = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [ROWS-1:0][DATA_W-1:0]  a_in,
  input  logic [COLS-1:0][DATA_W-1:0]  w_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [ROWS-1:0][ACC_W-1:0]   out_data,
  output logic                         out_valid,
  input  logic                         out_read,
  output logic                         busy
);

  // Cycles for the last beat to travel from PE(0,0) to PE(ROWS-1,COLS-1).
  localparam int FLUSH_N = ROWS + COLS - 1;
  localparam int BEAT_W  = cnt_w(K_LEN);
  localparam int FL_W    = cnt_w(FLUSH_N);
  localparam int DR_W    = cnt_w(COLS - 1);
  localparam int SK_A    = (ROWS > 1) ? ROWS - 1 : 1;
  localparam int SK_W    = (COLS > 1) ? COLS - 1 : 1;

  sa_state_e          r_state;
  sa_state_e          w_state_nxt;
  logic [BEAT_W-1:0]  r_beat_cnt;
  logic [BEAT_W-1:0]  w_beat_nxt;
  logic [FL_W-1:0]    r_flush_cnt;
  logic [FL_W-1:0]    w_flush_nxt;
  logic [DR_W-1:0]    r_drain_idx;
  logic [DR_W-1:0]    w_drain_nxt;
  logic [DR_W-1:0]    w_col_sel;
  logic               w_ld_out;
  logic               w_clr_out;
  logic               w_xfer;
  logic               w_first_in;
  logic [ROWS-1:0][ACC_W-1:0] r_out_data;

  // Skew delay lines; row r taps stage r-1, column c taps stage c-1.
  logic signed [DATA_W-1:0] r_a_sk   [ROWS][SK_A];
  logic                     r_a_sk_v [ROWS][SK_A];
  logic                     r_a_sk_f [ROWS][SK_A];
  logic signed [DATA_W-1:0] r_w_sk   [COLS][SK_W];
  logic                     r_w_sk_v [COLS][SK_W];
  logic                     r_w_sk_f [COLS][SK_W];

  // Inter-PE links: activations flow along rows, weights down columns.
  logic signed [DATA_W-1:0] w_a_d [ROWS][COLS+1];
  logic                     w_a_v [ROWS][COLS+1];
  logic                     w_a_f [ROWS][COLS+1];
  logic signed [DATA_W-1:0] w_w_d [ROWS+1][COLS];
  logic                     w_w_v [ROWS+1][COLS];
  logic                     w_w_f [ROWS+1][COLS];
  logic signed [ACC_W-1:0]  w_acc_grid [ROWS][COLS];

  // Handshake and status outputs decode only the registered state.
  assign in_ready   = (r_state == ST_IDLE) || (r_state == ST_LOAD);
  assign out_valid  = (r_state == ST_DRAIN);
  assign busy       = (r_state != ST_IDLE);
  assign out_data   = r_out_data;
  assign w_xfer     = in_valid & in_ready;
  assign w_first_in = w_xfer & (r_state == ST_IDLE);

  // Tile FSM state and counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_beat_cnt  <= '0;
      r_flush_cnt <= '0;
      r_drain_idx <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat_cnt  <= w_beat_nxt;
      r_flush_cnt <= w_flush_nxt;
      r_drain_idx <= w_drain_nxt;
    end
  end

  // Next-state, counter updates and drain-register load controls.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_cnt;
    w_flush_nxt = r_flush_cnt;
    w_drain_nxt = r_drain_idx;
    w_col_sel   = r_drain_idx;
    w_ld_out    = 1'b0;
    w_clr_out   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          w_beat_nxt  = BEAT_W'(1);
          w_flush_nxt = '0;
          if (K_LEN == 1) begin
            w_state_nxt = ST_FLUSH;
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end else begin
          w_beat_nxt = '0;
        end
      end
      ST_LOAD: begin
        if (w_xfer) begin
          w_beat_nxt = r_beat_cnt + BEAT_W'(1);
          if (r_beat_cnt == BEAT_W'(K_LEN - 1)) begin
            w_state_nxt = ST_FLUSH;
            w_flush_nxt = '0;
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_FLUSH: begin
        if (r_flush_cnt == FL_W'(FLUSH_N - 1)) begin
          w_state_nxt = ST_DRAIN;
          w_drain_nxt = '0;
          w_col_sel   = '0;
          w_ld_out    = 1'b1;
        end else begin
          w_flush_nxt = r_flush_cnt + FL_W'(1);
        end
      end
      ST_DRAIN: begin
        if (out_read) begin
          if (r_drain_idx == DR_W'(COLS - 1)) begin
            w_state_nxt = ST_IDLE;
            w_beat_nxt  = '0;
            w_drain_nxt = '0;
            w_clr_out   = 1'b1;
          end else begin
            w_drain_nxt = r_drain_idx + DR_W'(1);
            w_col_sel   = r_drain_idx + DR_W'(1);
            w_ld_out    = 1'b1;
          end
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Activation skew lines: shift every cycle, bubbles carry valid=0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int s = 0; s < SK_A; s++) begin
          r_a_sk[r][s]   <= '0;
          r_a_sk_v[r][s] <= 1'b0;
          r_a_sk_f[r][s] <= 1'b0;
        end
      end
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        r_a_sk[r][0]   <= a_in[r];
        r_a_sk_v[r][0] <= w_xfer;
        r_a_sk_f[r][0] <= w_first_in;
        for (int s = 1; s < SK_A; s++) begin
          r_a_sk[r][s]   <= r_a_sk[r][s-1];
          r_a_sk_v[r][s] <= r_a_sk_v[r][s-1];
          r_a_sk_f[r][s] <= r_a_sk_f[r][s-1];
        end
      end
    end
  end

  // Weight skew lines: shift every cycle, bubbles carry valid=0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < COLS; c++) begin
        for (int s = 0; s < SK_W; s++) begin
          r_w_sk[c][s]   <= '0;
          r_w_sk_v[c][s] <= 1'b0;
          r_w_sk_f[c][s] <= 1'b0;
        end
      end
    end else begin
      for (int c = 0; c < COLS; c++) begin
        r_w_sk[c][0]   <= w_in[c];
        r_w_sk_v[c][0] <= w_xfer;
        r_w_sk_f[c][0] <= w_first_in;
        for (int s = 1; s < SK_W; s++) begin
          r_w_sk[c][s]   <= r_w_sk[c][s-1];
          r_w_sk_v[c][s] <= r_w_sk_v[c][s-1];
          r_w_sk_f[c][s] <= r_w_sk_f[c][s-1];
        end
      end
    end
  end

  // Row entry points: row 0 is fed directly, row r after r delays.
  for (genvar gr = 0; gr < ROWS; gr++) begin : g_a_tap
    if (gr == 0) begin : g_direct
      assign w_a_d[gr][0] = a_in[gr];
      assign w_a_v[gr][0] = w_xfer;
      assign w_a_f[gr][0] = w_first_in;
    end else begin : g_skew
      assign w_a_d[gr][0] = r_a_sk[gr][gr-1];
      assign w_a_v[gr][0] = r_a_sk_v[gr][gr-1];
      assign w_a_f[gr][0] = r_a_sk_f[gr][gr-1];
    end
  end

  // Column entry points: column 0 is fed directly, column c after c delays.
  for (genvar gc = 0; gc < COLS; gc++) begin : g_w_tap
    if (gc == 0) begin : g_direct
      assign w_w_d[0][gc] = w_in[gc];
      assign w_w_v[0][gc] = w_xfer;
      assign w_w_f[0][gc] = w_first_in;
    end else begin : g_skew
      assign w_w_d[0][gc] = r_w_sk[gc][gc-1];
      assign w_w_v[0][gc] = r_w_sk_v[gc][gc-1];
      assign w_w_f[0][gc] = r_w_sk_f[gc][gc-1];
    end
  end

  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
      sa_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk   (clk),
        .rstn  (rstn),
        .i_a   (w_a_d[gr][gc]),
        .i_a_v (w_a_v[gr][gc]),
        .i_a_f (w_a_f[gr][gc]),
        .i_w   (w_w_d[gr][gc]),
        .i_w_v (w_w_v[gr][gc]),
        .i_w_f (w_w_f[gr][gc]),
        .o_a   (w_a_d[gr][gc+1]),
        .o_a_v (w_a_v[gr][gc+1]),
        .o_a_f (w_a_f[gr][gc+1]),
        .o_w   (w_w_d[gr+1][gc]),
        .o_w_v (w_w_v[gr+1][gc]),
        .o_w_f (w_w_f[gr+1][gc]),
        .o_acc (w_acc_grid[gr][gc])
      );
    end
  end

  // Registered drain mux: loads the next column, holds under back-pressure.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_data <= '0;
    end else if (w_ld_out) begin
      for (int r = 0; r < ROWS; r++) begin
        r_out_data[r] <= w_acc_grid[r][w_col_sel];
      end
    end else if (w_clr_out) begin
      r_out_data <= '0;
    end
  end

endmodule

// File: tb/tb_sa_array_os.sv
// Scoreboard bench for sa_array_os (default parameters, SA_SATURATE_EN
// undefined). Each tile's expected columns come from a plain matrix
// product of the issued operands; a monitor pops and compares on reads.
module tb_sa_array_os;

  localparam int R   = 8;
  localparam int C   = 8;
  localparam int DW  = 8;
  localparam int AW  = 32;
  localparam int K   = 16;
  localparam int OW  = R * AW;
  localparam int LAT = R + C - 1;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic [R-1:0][DW-1:0]  a_in;
  logic [C-1:0][DW-1:0]  w_in;
  logic                  in_valid;
  logic                  in_ready;
  logic [R-1:0][AW-1:0]  out_data;
  logic                  out_valid;
  logic                  out_read;
  logic                  busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [OW-1:0] sb [$];

  sa_array_os #(
    .ROWS(R), .COLS(C), .DATA_W(DW), .ACC_W(AW), .K_LEN(K)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .a_in      (a_in),
    .w_in      (w_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_read  (out_read),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // Monitor: compare each column as it is read; check hold stability.
  logic [OW-1:0] prev_data;
  bit            prev_hold = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && out_valid && out_read) begin
        if (sb.size() == 0) chk("unexpected_column", 1, 0);
        else                chk("column_data", out_data, sb.pop_front());
      end
      if (prev_hold && out_valid) chk("hold_stable", out_data, prev_data);
      prev_hold = rstn && out_valid && !out_read;
      prev_data = out_data;
    end
  end

  // kind: 0 random, 1 uniform (a=1,w=2), 2 outer product. bub: 0 none, 1 toggle, 2 random.
  task automatic send_tile(input int kind, input int bub);
    byte am [K][R];
    byte wm [K][C];
    logic [OW-1:0] col;
    int s, k, guard, n;
    bit v, tog;
    for (int i = 0; i < K; i++) begin
      for (int r = 0; r < R; r++)
        case (kind)
          1:       am[i][r] = 1;
          2:       am[i][r] = byte'(r);
          default: am[i][r] = byte'($urandom);
        endcase
      for (int c = 0; c < C; c++)
        case (kind)
          1:       wm[i][c] = 2;
          2:       wm[i][c] = byte'(c + 1);
          default: wm[i][c] = byte'($urandom);
        endcase
    end
    for (int c = 0; c < C; c++) begin
      col = '0;
      for (int r = 0; r < R; r++) begin
        s = 0;
        for (int i = 0; i < K; i++) s += int'(am[i][r]) * int'(wm[i][c]);
        col[r*AW +: AW] = s;
      end
      sb.push_back(col);
    end
    k = 0; guard = 0; tog = 1'b0;
    while (k < K && guard < 400) begin
      case (bub)
        0:       v = 1'b1;
        1:       v = !tog;
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      tog = !tog;
      in_valid = v;
      for (int r = 0; r < R; r++) a_in[r] = v ? am[k][r] : 8'($urandom);
      for (int c = 0; c < C; c++) w_in[c] = v ? wm[k][c] : 8'($urandom);
      @(negedge clk);
      if (guard == 0) chk("idle_busy", busy, 0);
      chk("load_in_ready", in_ready, 1);
      chk("load_out_valid", out_valid, 0);
      @(posedge clk); #1;
      if (v) k++;
      guard++;
    end
    if (k < K) chk("load_timeout", k, K);
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    chk("flush_busy", busy, 1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("out_valid_latency", n, LAT);
  endtask

  // mode: 0 read every cycle, 1 random reads, 2 stall 5 cycles after 3 reads.
  // abort_at > 0: assert reset after that many reads.
  task automatic drain(input int mode, input int abort_at);
    int reads, cyc, hold;
    bit rd;
    reads = 0; cyc = 0; hold = 0;
    while (reads < C && cyc < 300) begin
      @(posedge clk); #1;
      if (abort_at > 0 && reads == abort_at) break;
      if (mode == 2 && reads == 3 && hold < 5) begin
        rd = 1'b0;
        hold++;
      end else if (mode == 1) begin
        rd = 1'($urandom_range(0, 1));
      end else begin
        rd = 1'b1;
      end
      out_read = rd;
      @(negedge clk);
      if (!rd) chk("stall_out_valid", out_valid, 1);
      if (out_valid && rd) reads++;
      cyc++;
    end
    if (abort_at > 0) begin
      out_read = 1'b0;
      chk("abort_reads", reads, abort_at);
      #1 rstn = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_data", out_data, 0);
      sb.delete();
      @(negedge clk);
      #2 rstn = 1'b1;
      @(posedge clk); #1;
    end else begin
      chk("drain_reads", reads, C);
      @(posedge clk); #1;
      out_read = 1'b0;
    end
  endtask

  initial begin
    in_valid = 1'b0;
    out_read = 1'b0;
    a_in     = '0;
    w_in     = '0;
    #3;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_out_data", out_data, 0);
    #9 rstn = 1'b1;
    @(posedge clk); #1;

    send_tile(1, 0); drain(0, 0);   // uniform, back-to-back
    send_tile(2, 0); drain(1, 0);   // outer product, random reads
    send_tile(1, 1); drain(0, 0);   // uniform with toggling bubbles
    send_tile(0, 2); drain(2, 0);   // random with bubbles, back-pressure
    send_tile(0, 0); drain(0, 3);   // reset mid-drain
    send_tile(0, 2); drain(1, 0);   // next tile after reset
    send_tile(0, 0); drain(0, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
